// File: rtl/fetch_unit.sv
// fetch_unit: multi-lane instruction fetch with PC, hit-prefix enqueue and a circular instruction queue
module fetch_unit #(
    parameter int XLEN = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              stop,
    input  logic                              redirect,
    input  logic [XLEN-1:0]                   redirect_address,
    output logic [FETCH_WIDTH-1:0]            cache_read,
    output logic [FETCH_WIDTH-1:0][XLEN-1:0]  cache_address,
    input  logic [FETCH_WIDTH-1:0]            cache_hit,
    input  logic [FETCH_WIDTH-1:0][31:0]      cache_data,
    output logic [FETCH_WIDTH-1:0]            out_valid,
    output logic [FETCH_WIDTH-1:0][XLEN-1:0]  out_address,
    output logic [FETCH_WIDTH-1:0][31:0]      out_instr,
    input  logic                              out_ready,
    output logic                              miss
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(FETCH_WIDTH + 1);

    logic [XLEN-1:0] pc;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, free, deq;
    logic [KW-1:0]   k, enq;
    logic            enable, run;
    logic [XLEN-1:0] mem_addr [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic            unused_bits;

    assign unused_bits = ^redirect_address[1:0];
    assign free = CW'(DEPTH) - count;
    assign enable = reset && !stop && !redirect && free >= CW'(FETCH_WIDTH);
    assign cache_read = {FETCH_WIDTH{enable}};
    assign miss = enable && !cache_hit[0];
    assign enq = enable ? k : '0;
    assign deq = out_ready ? (count < CW'(FETCH_WIDTH) ? count : CW'(FETCH_WIDTH)) : '0;

    // hit prefix length, per-lane fetch addresses and the queue head presented on the output lanes
    always_comb begin
        k = '0;
        run = 1'b1;
        out_valid = '0;
        out_address = '0;
        out_instr = '0;
        cache_address = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            run = run & cache_hit[i];
            k = k + KW'(run);
            cache_address[i] = pc + XLEN'(4 * i);
            out_valid[i] = CW'(i) < count;
            out_address[i] = out_valid[i] ? mem_addr[head + PW'(i)] : '0;
            out_instr[i] = out_valid[i] ? mem_instr[head + PW'(i)] : '0;
        end
    end

    // PC and queue bookkeeping; redirect flushes and retargets, otherwise enqueue and dequeue both apply
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (redirect) begin
            pc <= {redirect_address[XLEN-1:2], 2'b00};
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            pc <= pc + (XLEN'(enq) << 2);
            head <= head + PW'(deq);
            tail <= tail + PW'(enq);
            count <= count + CW'(enq) - deq;
        end
    end

    // store the hit lanes at the tail in lane order; occupancy alone decides what is valid
    always_ff @(posedge clock) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (KW'(i) < enq) begin
                mem_addr[tail + PW'(i)] <= cache_address[i];
                mem_instr[tail + PW'(i)] <= cache_data[i];
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, async-reset sequence and random run against a queue model
module tb_fetch_unit;
    localparam int FW = 2;
    localparam int DEPTH = 8;
    localparam logic [31:0] RV = 32'h100;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] ra;
        logic [1:0]  hit;
        logic        rdy;
        logic [1:0]  e_read;
        logic [31:0] e_a0;
        logic [31:0] e_a1;
        logic        e_miss;
        logic [1:0]  e_valid;
        logic [31:0] e_o0;
        logic [31:0] e_o1;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic stop = 1'b0;
    logic redirect = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] redirect_address = '0;
    logic [FW-1:0] cache_hit = '0;
    logic [FW-1:0] cache_read, out_valid;
    logic [FW-1:0][31:0] cache_address, cache_data, out_address, out_instr;
    logic miss;
    int tests = 0;
    int fails = 0;
    vec_t tbl [19];
    ent_t model_q [$];
    logic [31:0] mpc;

    always #5 clock = ~clock;

    fetch_unit #(.XLEN(32), .FETCH_WIDTH(FW), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .clock(clock), .reset(reset), .stop(stop), .redirect(redirect),
        .redirect_address(redirect_address), .cache_read(cache_read),
        .cache_address(cache_address), .cache_hit(cache_hit), .cache_data(cache_data),
        .out_valid(out_valid), .out_address(out_address), .out_instr(out_instr),
        .out_ready(out_ready), .miss(miss)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // the instruction cache returns a fixed word derived from each requested address
    always_comb begin
        cache_data = '0;
        for (int i = 0; i < FW; i++) cache_data[i] = word_at(cache_address[i]);
    end

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic en;
        logic [FW-1:0] ev;
        logic [FW-1:0][31:0] ea, eo, ei, ao, ai;
        en = !stop && !redirect && (DEPTH - model_q.size() >= FW);
        for (int i = 0; i < FW; i++) begin
            ea[i] = mpc + 32'(4 * i);
            ev[i] = i < model_q.size();
            eo[i] = ev[i] ? model_q[i].a : 32'h0;
            ei[i] = ev[i] ? model_q[i].d : 32'h0;
            ao[i] = ev[i] ? out_address[i] : 32'h0;
            ai[i] = ev[i] ? out_instr[i] : 32'h0;
        end
        cmp("rnd cache_read", 128'(cache_read), 128'(en ? {FW{1'b1}} : {FW{1'b0}}));
        if (en) cmp("rnd cache_address", 128'(cache_address), 128'(ea));
        cmp("rnd miss", 128'(miss), 128'(en && !cache_hit[0]));
        cmp("rnd out_valid", 128'(out_valid), 128'(ev));
        cmp("rnd out_lanes", {ao, ai}, {eo, ei});
    endtask

    task automatic model_update();
        logic en;
        if (redirect) begin
            model_q.delete();
            mpc = {redirect_address[31:2], 2'b00};
        end else begin
            en = !stop && (DEPTH - model_q.size() >= FW);
            if (out_ready)
                for (int n = 0; n < FW && model_q.size() > 0; n++) void'(model_q.pop_front());
            if (en)
                for (int i = 0; i < FW && cache_hit[i]; i++) begin
                    model_q.push_back('{mpc, word_at(mpc)});
                    mpc = mpc + 32'd4;
                end
        end
    endtask

    initial begin
        tbl[0]  = '{0, 0, 32'h0, 2'b11, 0, 2'b11, 32'h100, 32'h104, 0, 2'b00, 32'h0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0, 2'b11, 0, 2'b11, 32'h108, 32'h10C, 0, 2'b11, 32'h100, 32'h104};
        tbl[2]  = '{0, 0, 32'h0, 2'b11, 0, 2'b11, 32'h110, 32'h114, 0, 2'b11, 32'h100, 32'h104};
        tbl[3]  = '{0, 0, 32'h0, 2'b11, 0, 2'b11, 32'h118, 32'h11C, 0, 2'b11, 32'h100, 32'h104};
        tbl[4]  = '{0, 0, 32'h0, 2'b11, 0, 2'b00, 32'h120, 32'h124, 0, 2'b11, 32'h100, 32'h104};
        tbl[5]  = '{0, 0, 32'h0, 2'b11, 1, 2'b00, 32'h120, 32'h124, 0, 2'b11, 32'h100, 32'h104};
        tbl[6]  = '{0, 0, 32'h0, 2'b11, 0, 2'b11, 32'h120, 32'h124, 0, 2'b11, 32'h108, 32'h10C};
        tbl[7]  = '{0, 0, 32'h0, 2'b00, 1, 2'b00, 32'h128, 32'h12C, 0, 2'b11, 32'h108, 32'h10C};
        tbl[8]  = '{0, 0, 32'h0, 2'b10, 0, 2'b11, 32'h128, 32'h12C, 1, 2'b11, 32'h110, 32'h114};
        tbl[9]  = '{0, 0, 32'h0, 2'b01, 0, 2'b11, 32'h128, 32'h12C, 0, 2'b11, 32'h110, 32'h114};
        tbl[10] = '{0, 0, 32'h0, 2'b11, 0, 2'b00, 32'h12C, 32'h130, 0, 2'b11, 32'h110, 32'h114};
        tbl[11] = '{0, 1, 32'h403, 2'b11, 1, 2'b00, 32'h12C, 32'h130, 0, 2'b11, 32'h110, 32'h114};
        tbl[12] = '{0, 0, 32'h0, 2'b11, 1, 2'b11, 32'h400, 32'h404, 0, 2'b00, 32'h0, 32'h0};
        tbl[13] = '{0, 0, 32'h0, 2'b00, 1, 2'b11, 32'h408, 32'h40C, 1, 2'b11, 32'h400, 32'h404};
        tbl[14] = '{1, 0, 32'h0, 2'b11, 0, 2'b00, 32'h408, 32'h40C, 0, 2'b00, 32'h0, 32'h0};
        tbl[15] = '{0, 1, 32'hFFFF_FFFE, 2'b11, 0, 2'b00, 32'h408, 32'h40C, 0, 2'b00, 32'h0, 32'h0};
        tbl[16] = '{0, 0, 32'h0, 2'b11, 0, 2'b11, 32'hFFFF_FFFC, 32'h0, 0, 2'b00, 32'h0, 32'h0};
        tbl[17] = '{0, 0, 32'h0, 2'b00, 1, 2'b11, 32'h4, 32'h8, 1, 2'b11, 32'hFFFF_FFFC, 32'h0};
        tbl[18] = '{0, 0, 32'h0, 2'b00, 0, 2'b11, 32'h4, 32'h8, 1, 2'b00, 32'h0, 32'h0};

        #3;
        cmp("reset cache_read", 128'(cache_read), 128'(0));
        cmp("reset out_valid", 128'(out_valid), 128'(0));
        cmp("reset miss", 128'(miss), 128'(0));
        cmp("reset out_lanes", {out_address, out_instr}, 128'(0));
        @(negedge clock);
        reset = 1'b1;

        for (int r = 0; r < 19; r++) begin
            @(negedge clock);
            stop = tbl[r].st;
            redirect = tbl[r].rd;
            redirect_address = tbl[r].ra;
            cache_hit = tbl[r].hit;
            out_ready = tbl[r].rdy;
            #1;
            cmp($sformatf("vec%0d cache_read", r), 128'(cache_read), 128'(tbl[r].e_read));
            cmp($sformatf("vec%0d cache_address", r), 128'(cache_address), 128'({tbl[r].e_a1, tbl[r].e_a0}));
            cmp($sformatf("vec%0d miss", r), 128'(miss), 128'(tbl[r].e_miss));
            cmp($sformatf("vec%0d out_valid", r), 128'(out_valid), 128'(tbl[r].e_valid));
            if (tbl[r].e_valid[0]) begin
                cmp($sformatf("vec%0d out_address0", r), 128'(out_address[0]), 128'(tbl[r].e_o0));
                cmp($sformatf("vec%0d out_instr0", r), 128'(out_instr[0]), 128'(word_at(tbl[r].e_o0)));
            end
            if (tbl[r].e_valid[1])
                cmp($sformatf("vec%0d out_address1", r), 128'(out_address[1]), 128'(tbl[r].e_o1));
        end

        // fill six entries from PC 0x4, then pull reset low between edges with a hit pending
        redirect = 1'b0;
        stop = 1'b0;
        out_ready = 1'b0;
        cache_hit = 2'b11;
        repeat (3) @(negedge clock);
        #1;
        cmp("pre-reset out_valid", 128'(out_valid), 128'(2'b11));
        cmp("pre-reset out_address0", 128'(out_address[0]), 128'(32'h4));
        cmp("pre-reset cache_read", 128'(cache_read), 128'(2'b11));
        #1;
        reset = 1'b0;
        #1;
        cmp("async reset out_valid", 128'(out_valid), 128'(0));
        cmp("async reset cache_read", 128'(cache_read), 128'(0));
        cmp("async reset miss", 128'(miss), 128'(0));
        cmp("async reset out_lanes", {out_address, out_instr}, 128'(0));
        @(negedge clock);
        reset = 1'b1;
        #1;
        cmp("release cache_read", 128'(cache_read), 128'(2'b11));
        cmp("release cache_address", 128'(cache_address), 128'({32'h104, 32'h100}));
        cmp("release out_valid", 128'(out_valid), 128'(0));
        @(negedge clock);
        #1;
        cmp("resume out_valid", 128'(out_valid), 128'(2'b11));
        cmp("resume out_address", 128'(out_address), 128'({32'h104, 32'h100}));

        @(negedge clock);
        reset = 1'b0;
        cache_hit = '0;
        @(negedge clock);
        reset = 1'b1;
        model_q.delete();
        mpc = RV;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            stop = ($urandom % 8) == 0;
            redirect = ($urandom % 24) == 0;
            redirect_address = ($urandom % 2) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            cache_hit = {($urandom % 4) != 0, ($urandom % 4) != 0};
            out_ready = ($urandom % 100) < (((c / 200) % 2) ? 80 : 25);
            #1;
            model_check();
            model_update();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
